// File: rtl/array_sum_ctrl_if.sv
// Request, memory-read and result signals of the array summing controller.
// The controller takes the slave modport. The requesters and the memory take the master modport.
interface array_sum_ctrl_if;
    logic [1:0]  req;
    logic [7:0]  base_0;
    logic [8:0]  len_0;
    logic [7:0]  base_1;
    logic [8:0]  len_1;
    logic [1:0]  grant;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic [31:0] sum;
    logic        ovf;
    logic [1:0]  done;
    logic        busy;

    modport slave (
        input  req, base_0, len_0, base_1, len_1, mem_data,
        output grant, mem_rd, mem_addr, sum, ovf, done, busy
    );

    modport master (
        output req, base_0, len_0, base_1, len_1, mem_data,
        input  grant, mem_rd, mem_addr, sum, ovf, done, busy
    );
endinterface

// File: rtl/array_sum_ctrl.sv
// Two-port round-robin job controller. Each job reads len words from base upward
// and sums them. Read data comes back one cycle after its strobe.
//
// state | meaning
// IDLE  | waiting for a request; accepts one port per edge
// READ  | issuing mem_rd, one address per cycle, down-counting reads left
// DRAIN | absorbing the last data beat
// DONE  | done pulse for the served port; sum/ovf final
module array_sum_ctrl (
    input  logic             clk,
    input  logic             reset,
    array_sum_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t      state, state_n;
    logic        last, last_n;
    logic        port, port_n;
    logic [8:0]  cnt, cnt_n;
    logic [7:0]  addr, addr_n;
    logic        rd, rd_n;
    logic        dv;
    logic [31:0] sum, sum_n;
    logic        ovf, ovf_n;
    logic [1:0]  grant, grant_n;
    logic [1:0]  done, done_n;
    logic        busy;
    logic        win;
    logic [7:0]  sel_base;
    logic [8:0]  sel_len;
    logic [32:0] acc;

    always_comb begin
        // On a tie, serve the port that was not served last.
        win      = (bus.req == 2'b11) ? ~last : bus.req[1];
        sel_base = win ? bus.base_1 : bus.base_0;
        sel_len  = win ? bus.len_1  : bus.len_0;
        acc      = {1'b0, sum} + {1'b0, bus.mem_data};

        state_n = state;
        last_n  = last;
        port_n  = port;
        cnt_n   = cnt;
        addr_n  = addr;
        rd_n    = 1'b0;
        grant_n = 2'b00;
        done_n  = 2'b00;
        sum_n   = sum;
        ovf_n   = ovf;

        if (dv) begin
            sum_n = acc[31:0];
            ovf_n = ovf | acc[32];
        end

        case (state)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    port_n  = win;
                    last_n  = win;
                    grant_n = win ? 2'b10 : 2'b01;
                    sum_n   = 32'd0;
                    ovf_n   = 1'b0;
                    if (sel_len != 9'd0) begin
                        rd_n    = 1'b1;
                        addr_n  = sel_base;
                        cnt_n   = sel_len - 9'd1;
                        state_n = READ;
                    end else begin
                        state_n = DRAIN;
                    end
                end
            end
            READ: begin
                if (cnt == 9'd0) begin
                    state_n = DRAIN;
                end else begin
                    rd_n   = 1'b1;
                    addr_n = addr + 8'd1;
                    cnt_n  = cnt - 9'd1;
                end
            end
            DRAIN: begin
                done_n  = port ? 2'b10 : 2'b01;
                state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
            port  <= 1'b0;
            cnt   <= 9'd0;
            addr  <= 8'd0;
            rd    <= 1'b0;
            dv    <= 1'b0;
            sum   <= 32'd0;
            ovf   <= 1'b0;
            grant <= 2'b00;
            done  <= 2'b00;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            last  <= last_n;
            port  <= port_n;
            cnt   <= cnt_n;
            addr  <= addr_n;
            rd    <= rd_n;
            dv    <= rd;
            sum   <= sum_n;
            ovf   <= ovf_n;
            grant <= grant_n;
            done  <= done_n;
            busy  <= (state_n != IDLE);
        end
    end

    assign bus.grant    = grant;
    assign bus.mem_rd   = rd;
    assign bus.mem_addr = addr;
    assign bus.sum      = sum;
    assign bus.ovf      = ovf;
    assign bus.done     = done;
    assign bus.busy     = busy;
endmodule
